mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream program/data loader with processor start handshake
//
// Purpose: receives a byte stream that carries an instruction-memory image and a
// data-memory image, writes them word by word, then starts the processor and
// waits for it to finish.
//
// Stream layout: IM count (2 bytes LE) | IM words (4 bytes LE each) |
//                DM count (2 bytes LE) | DM words | [checksum byte]
//
// Optional feature macro: MEM_LOADER_CHECKSUM_EN
//   When defined, every byte from the IM count through the last DM word is XORed
//   and one trailing checksum byte is checked before the processor is started.
//
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   loadEn                         start a new load (honoured in IDLE/DONE/ERR only)
//   rxData, rxValid, rxReady       byte input handshake
//   imWrEn, imAddr, imWrData       instruction memory write port
//   dmWrEn, dmAddr, dmWrData       data memory write port
//   startProcess, endProcess       processor start pulse / completion input
//   busy, done, error              status
module mem_loader #(
    parameter int IM_MEM_DEPTH = 256,
    parameter int DM_MEM_DEPTH = 4096,
    localparam int IM_AW = $clog2(IM_MEM_DEPTH),
    localparam int DM_AW = $clog2(DM_MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             loadEn,
    input  logic [7:0]       rxData,
    input  logic             rxValid,
    output logic             rxReady,
    output logic             imWrEn,
    output logic [IM_AW-1:0] imAddr,
    output logic [31:0]      imWrData,
    output logic             dmWrEn,
    output logic [DM_AW-1:0] dmAddr,
    output logic [31:0]      dmWrData,
    output logic             startProcess,
    input  logic             endProcess,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [3:0] {
        S_IDLE, S_IM_LEN, S_IM_DATA, S_DM_LEN, S_DM_DATA,
        S_START, S_RUN, S_DONE, S_ERR
`ifdef MEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DM = S_CHK;
    localparam bit     GO_START   = 1'b0;
`else
    localparam state_t S_AFTER_DM = S_START;
    localparam bit     GO_START   = 1'b1;
`endif

    state_t      r_state;
    logic [1:0]  r_byte_cnt;    // byte position inside the current count/word
    logic [7:0]  r_len_lo;      // low byte of the word count
    logic [23:0] r_word;        // first three bytes of the word being assembled
    logic [15:0] r_remaining;   // words still to be written in the current *_DATA state
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_accept;
    logic [15:0] w_len;

    assign w_accept = rxValid && rxReady;
    assign w_len    = {rxData, r_len_lo};

    always_comb begin
        rxReady = 1'b0;
        case (r_state)
            S_IM_LEN, S_IM_DATA, S_DM_LEN, S_DM_DATA: rxReady = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            S_CHK:                                     rxReady = 1'b1;
`endif
            default:                                   rxReady = 1'b0;
        endcase
    end

    assign busy = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_len_lo     <= 8'd0;
            r_word       <= 24'd0;
            r_remaining  <= 16'd0;
            imWrEn       <= 1'b0;
            imAddr       <= '0;
            imWrData     <= 32'd0;
            dmWrEn       <= 1'b0;
            dmAddr       <= '0;
            dmWrData     <= 32'd0;
            startProcess <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
        end else begin
            imWrEn       <= 1'b0;
            dmWrEn       <= 1'b0;
            startProcess <= 1'b0;
            // The address presented with a write pulse is the word index; it
            // advances once that write has been issued.
            if (imWrEn) imAddr <= imAddr + IM_AW'(1);
            if (dmWrEn) dmAddr <= dmAddr + DM_AW'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
            if (w_accept && r_state != S_CHK) r_xor <= r_xor ^ rxData;
`endif
            // Bytes within a word land in ascending lanes; lane 3 goes straight to WrData.
            if (w_accept && (r_state == S_IM_DATA || r_state == S_DM_DATA)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_word[7:0]   <= rxData;
                    2'd1:    r_word[15:8]  <= rxData;
                    2'd2:    r_word[23:16] <= rxData;
                    default: r_word        <= r_word;
                endcase
            end

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (loadEn) begin
                        r_state    <= S_IM_LEN;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        imAddr     <= '0;
                        dmAddr     <= '0;
                        r_byte_cnt <= 2'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_xor      <= 8'd0;
`endif
                    end
                end
                S_IM_LEN: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd0) begin
                            r_len_lo   <= rxData;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_byte_cnt <= 2'd0;
                            if ({16'd0, w_len} > 32'(IM_MEM_DEPTH)) begin
                                r_state <= S_ERR;
                                error   <= 1'b1;
                            end else if (w_len == 16'd0) begin
                                r_state <= S_DM_LEN;
                            end else begin
                                r_remaining <= w_len;
                                r_state     <= S_IM_DATA;
                            end
                        end
                    end
                end
                S_IM_DATA: begin
                    if (w_accept && r_byte_cnt == 2'd3) begin
                        imWrEn      <= 1'b1;
                        imWrData    <= {rxData, r_word};
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) r_state <= S_DM_LEN;
                    end
                end
                S_DM_LEN: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd0) begin
                            r_len_lo   <= rxData;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_byte_cnt <= 2'd0;
                            if ({16'd0, w_len} > 32'(DM_MEM_DEPTH)) begin
                                r_state <= S_ERR;
                                error   <= 1'b1;
                            end else if (w_len == 16'd0) begin
                                r_state      <= S_AFTER_DM;
                                startProcess <= GO_START;
                            end else begin
                                r_remaining <= w_len;
                                r_state     <= S_DM_DATA;
                            end
                        end
                    end
                end
                S_DM_DATA: begin
                    if (w_accept && r_byte_cnt == 2'd3) begin
                        dmWrEn      <= 1'b1;
                        dmWrData    <= {rxData, r_word};
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state      <= S_AFTER_DM;
                            startProcess <= GO_START;
                        end
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        if (rxData == r_xor) begin
                            r_state      <= S_START;
                            startProcess <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                // startProcess is raised on entry, so it is high exactly while in START.
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (endProcess) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader
module tb_mem_loader;

    localparam int IMD = 256;
    localparam int DMD = 4096;

    logic        clk = 1'b0;
    logic        rstN;
    logic        loadEn;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        imWrEn;
    logic [7:0]  imAddr;
    logic [31:0] imWrData;
    logic        dmWrEn;
    logic [11:0] dmAddr;
    logic [31:0] dmWrData;
    logic        startProcess;
    logic        endProcess;
    logic        busy;
    logic        done;
    logic        error;

    mem_loader #(.IM_MEM_DEPTH(IMD), .DM_MEM_DEPTH(DMD)) dut (
        .clk(clk), .rstN(rstN), .loadEn(loadEn),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .imWrEn(imWrEn), .imAddr(imAddr), .imWrData(imWrData),
        .dmWrEn(dmWrEn), .dmAddr(dmAddr), .dmWrData(dmWrData),
        .startProcess(startProcess), .endProcess(endProcess),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dm;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    bit  exp_err;
    bit  exp_start;
    int  started;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: walks the stream by its framing rules and lists the
    // writes that must appear, plus whether the run ends in start or error.
    task automatic model_build(input logic [7:0] s[$]);
        int p;
        int n;
        p = 0;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_start = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n = int'(s[p]) + 256 * int'(s[p+1]);
            p += 2;
            if (n > ((m == 1) ? DMD : IMD)) begin
                exp_err = 1'b1;
                return;
            end
            for (int w = 0; w < n; w++) begin
                exp_q.push_back('{dm: (m == 1), addr: w,
                                  data: {s[p+3], s[p+2], s[p+1], s[p]}});
                p += 4;
            end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 0; i < p; i++) x = x ^ s[i];
            if (s[p] != x) begin
                exp_err = 1'b1;
                return;
            end
        end
`endif
        exp_start = 1'b1;
    endtask

    function automatic void add_chk(ref logic [7:0] s[$], input bit bad);
`ifdef MEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(bad ? (x ^ 8'h01) : x);
`else
        if (bad) s = s;
`endif
    endfunction

    // Compare process: every write pulse is matched against the model's list.
    always @(negedge clk) begin
        if (rstN) begin
            if (imWrEn || dmWrEn) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got im=%0b dm=%0b expected none", imWrEn, dmWrEn);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (imWrEn)
                        chk($sformatf("im_write%0d", e.addr), {e.dm, 7'd0, imAddr, imWrData[15:0]} ^ {16'd0, imWrData[31:16]} ,
                            {1'b0, 7'd0, e.addr[7:0], e.data[15:0]} ^ {16'd0, e.data[31:16]});
                    if (imWrEn) chk("im_wdata", imWrData, e.data);
                    if (dmWrEn) begin
                        chk("dm_sel", {31'd0, e.dm}, 32'd1);
                        chk("dm_addr", {20'd0, dmAddr}, e.addr);
                        chk("dm_wdata", dmWrData, e.data);
                    end
                end
            end
            if (startProcess) started++;
        end
    end

    task automatic pulse_load();
        loadEn = 1'b1;
        @(posedge clk); #1;
        loadEn = 1'b0;
    endtask

    task automatic send(input logic [7:0] s[$], input bit gap, input int end_at);
        for (int i = 0; i < s.size(); i++) begin
            int t;
            if (i == end_at) begin
                rxValid    = 1'b0;
                endProcess = 1'b1;
                @(posedge clk); #1;
                endProcess = 1'b0;
            end
            rxData  = s[i];
            rxValid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!rxReady && t < 200);
            if (!rxReady) begin
                chk("rx_ready_timeout", 32'd0, 32'd1);
                rxValid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gap) begin
                rxValid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rxValid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] s[$], input bit gap, input int end_at, input bit ld_in_run);
        int t;
        model_build(s);
        started = 0;
        pulse_load();
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        chk("error_cleared", {31'd0, error}, 32'd0);
        chk("done_cleared", {31'd0, done}, 32'd0);
        send(s, gap, end_at);
        if (exp_start) begin
            t = 0;
            while (started == 0 && t < 50) begin
                @(negedge clk); #1;
                t++;
            end
            chk("start_seen", started, 32'd1);
            chk("busy_in_run", {31'd0, busy}, 32'd1);
            if (ld_in_run) begin
                pulse_load();
                chk("rxready_in_run", {31'd0, rxReady}, 32'd0);
            end
            repeat (3) @(posedge clk);
            #1;
            chk("single_start", started, 32'd1);
            chk("done_before_end", {31'd0, done}, 32'd0);
            endProcess = 1'b1;
            @(posedge clk); #1;
            endProcess = 1'b0;
            @(negedge clk); #1;
            chk("done_after_end", {31'd0, done}, 32'd1);
            chk("busy_after_end", {31'd0, busy}, 32'd0);
        end else begin
            repeat (5) @(negedge clk);
            #1;
            chk("error_set", {31'd0, error}, 32'd1);
            chk("busy_in_err", {31'd0, busy}, 32'd0);
            chk("no_start", started, 32'd0);
        end
        chk("writes_left", exp_q.size(), 32'd0);
    endtask

    logic [7:0] s_main[$];
    logic [7:0] s_tmp[$];

    initial begin
        rstN = 1'b0; loadEn = 1'b0; rxData = 8'd0; rxValid = 1'b0; endProcess = 1'b0;
        started = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rxready", {31'd0, rxReady}, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("rst_wr", {30'd0, imWrEn, dmWrEn}, 32'd0);
        chk("rst_start", {31'd0, startProcess}, 32'd0);
        chk("rst_addr", {12'd0, imAddr, dmAddr}, 32'd0);
        chk("rst_data", imWrData | dmWrData, 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        s_main = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                   8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk(s_main, 1'b0);

        // Hand-computed expectations that pin the model itself.
        model_build(s_main);
        chk("model_count", exp_q.size(), 32'd3);
        chk("model_w0", exp_q[0].data, 32'h00000013);
        chk("model_w1", exp_q[1].data, 32'h00100093);
        chk("model_w2", exp_q[2].data, 32'hDEADBEEF);
        chk("model_w2_dm", {31'd0, exp_q[2].dm}, 32'd1);
        chk("model_start", {31'd0, exp_start}, 32'd1);

        run_load(s_main, 1'b0, -1, 1'b0);
        run_load(s_main, 1'b1, -1, 1'b0);

        s_tmp = '{8'h01, 8'h01};
        run_load(s_tmp, 1'b0, -1, 1'b0);
        run_load(s_main, 1'b0, -1, 1'b0);

        s_tmp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        add_chk(s_tmp, 1'b0);
        run_load(s_tmp, 1'b0, -1, 1'b0);
        s_tmp = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00};
        add_chk(s_tmp, 1'b0);
        run_load(s_tmp, 1'b1, -1, 1'b0);
        s_tmp = '{8'h00, 8'h00, 8'h01, 8'h10};
        run_load(s_tmp, 1'b0, -1, 1'b0);

        run_load(s_main, 1'b0, 4, 1'b1);

        // Reset after 6 bytes: exactly one IM write precedes it.
        exp_q.delete();
        exp_q.push_back('{dm: 1'b0, addr: 0, data: 32'h00000013});
        started = 0;
        pulse_load();
        s_tmp = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send(s_tmp, 1'b0, -1);
        chk("pre_rst_wr", {31'd0, imWrEn}, 32'd1);
        @(negedge clk); #1;
        rstN = 1'b0;
        #1;
        chk("midrst_wr", {30'd0, imWrEn, dmWrEn}, 32'd0);
        chk("midrst_status", {28'd0, rxReady, busy, done, error}, 32'd0);
        chk("midrst_addr", {12'd0, imAddr, dmAddr}, 32'd0);
        chk("midrst_data", imWrData, 32'd0);
        chk("midrst_writes_left", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        run_load(s_main, 1'b0, -1, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
        s_tmp = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                  8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk(s_tmp, 1'b1);
        run_load(s_tmp, 1'b0, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
